// File: rtl/mips_instr_sequencer.sv
// Loadable program buffer that sequences core reset, then serves instructions
// by PC (ADDR) or one word per cycle (STREAM), ending with drain and status.
module mips_instr_sequencer #(
  parameter int PC_WIDTH        = 32,
  parameter int INSTR_WIDTH     = 32,
  parameter int DEPTH           = 256,
  parameter int RESET_CYCLES    = 1,
  parameter int DRAIN_CYCLES    = 10,
  parameter int WATCHDOG_CYCLES = 100000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       restart,
  input  logic                       mode,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [INSTR_WIDTH-1:0]     ld_data,
  input  logic                       ld_last,
  output logic                       core_rst_n,
  input  logic [PC_WIDTH-1:0]        pc,
  output logic [INSTR_WIDTH-1:0]     instr,
  output logic [$clog2(DEPTH):0]     prog_len,
  output logic [$clog2(DEPTH):0]     issued,
  output logic                       done,
  output logic                       timeout,
  output logic [2:0]                 state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = $clog2(WATCHDOG_CYCLES + 1);
  localparam int XW   = (PC_WIDTH - 2 > AW + 1) ? PC_WIDTH - 2 : AW + 1;

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_L   = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_CORE_RST = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_e;

  // Load port: a word transfers on a cycle where ld_valid && ld_ready and
  // restart is low; ld_data/ld_last are sampled only on that cycle.

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic [AW:0]       issued_q, issued_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              mode_q, mode_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic          hs;
  logic          in_range;
  logic [XW-1:0] widx_x;
  logic [XW-1:0] plen_x;
  logic          unused_pc;

  assign widx_x    = XW'(pc[PC_WIDTH-1:2]);
  assign plen_x    = XW'(prog_len_q);
  assign in_range  = (widx_x < plen_x);
  assign unused_pc = ^pc[1:0];

  assign ld_ready = (state_q == S_LOAD) && (prog_len_q < DEPTH_L);
  assign hs       = ld_valid && ld_ready && !restart;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    prog_len_d = prog_len_q;
    issued_d   = issued_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    mode_d     = mode_q;
    instr      = NOP_INSTR;

    case (state_q)
      S_LOAD: begin
        if (hs) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          if (ld_last || prog_len_q == LAST_L) begin
            state_d = S_CORE_RST;
            mode_d  = mode;
            cnt_d   = '0;
            wdog_d  = '0;
          end
        end
      end
      S_CORE_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!mode_q) begin
          if (in_range) instr = mem[pc[AW+1:2]];
          else          state_d = S_DRAIN;
        end else begin
          instr    = mem[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (issued_q < DEPTH_L) issued_d = issued_q + 1'b1;
          if (issued_q == prog_len_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRN_LAST) state_d = S_DONE;
      end
      default: ;
    endcase

    // Watchdog expiry overrides every normal transition, including DRAIN->DONE.
    if (state_q == S_CORE_RST || state_q == S_RUN || state_q == S_DRAIN) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_q == WD_LAST) state_d = S_TIMEOUT;
    end

    if (restart) begin
      state_d    = S_LOAD;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      prog_len_d = '0;
      issued_d   = '0;
      cnt_d      = '0;
      wdog_d     = '0;
      mode_d     = 1'b0;
    end
  end

  // Core reset is decoded from the next state and registered so it never glitches.
  assign core_rst_n_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      prog_len_q   <= '0;
      issued_q     <= '0;
      cnt_q        <= '0;
      wdog_q       <= '0;
      mode_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      prog_len_q   <= prog_len_d;
      issued_q     <= issued_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      mode_q       <= mode_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) mem[wr_ptr_q] <= ld_data;
  end

  assign core_rst_n = core_rst_n_q;
  assign prog_len   = prog_len_q;
  assign issued     = issued_q;
  assign done       = (state_q == S_DONE);
  assign timeout    = (state_q == S_TIMEOUT);
  assign state      = state_q;

endmodule

// File: tb/tb_mips_instr_sequencer.sv
// Randomized bench for mips_instr_sequencer: expected per-cycle behaviour is
// derived from program length, mode and PC sequence with plain arithmetic.
module tb_mips_instr_sequencer;

  localparam int          DEPTH = 4;
  localparam int          RST_C = 1;
  localparam int          DRN_C = 10;
  localparam int          WD    = 50;
  localparam int          KMAX  = 64;
  localparam logic [31:0] NOP   = 32'h0BAD_F00D;

  logic        clk, rst_n, restart, mode, ld_valid, ld_ready, ld_last, core_rst_n;
  logic [31:0] ld_data, pc, instr;
  logic [2:0]  prog_len, issued, state;
  logic        done, timeout;

  mips_instr_sequencer #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .RESET_CYCLES(RST_C),
    .DRAIN_CYCLES(DRN_C), .WATCHDOG_CYCLES(WD), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .mode(mode),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .core_rst_n(core_rst_n), .pc(pc), .instr(instr), .prog_len(prog_len),
    .issued(issued), .done(done), .timeout(timeout), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] prog[DEPTH];
  logic [31:0] pc_seq[KMAX];
  int          plen;
  logic        mode_s;
  int          run_len;
  int          k_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases laid out along the cycle axis k, k=0 being the
  // first cycle after the LOAD exit.
  task automatic compute_model();
    if (mode_s) run_len = plen;
    else begin
      run_len = 1 << 20;
      for (int r = 0; RST_C + r < KMAX; r++) begin
        if ((pc_seq[RST_C + r] >> 2) >= 32'(plen)) begin
          run_len = r + 1;
          break;
        end
      end
    end
    k_done = RST_C + run_len + DRN_C;
  endtask

  function automatic int exp_state(input int k);
    if (k >= WD && k_done >= WD) return 5;
    if (k < RST_C)               return 1;
    if (k < RST_C + run_len)     return 2;
    if (k < k_done)              return 3;
    return 4;
  endfunction

  // driver tasks
  task automatic restart_pulse();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic load_prog(input int n, input logic with_last);
    int acc   = 0;
    int guard = 0;
    logic hs;
    while (acc < n && guard < 20) begin
      ld_valid = 1'b1;
      ld_data  = prog[acc];
      ld_last  = with_last && (acc == n - 1);
      @(negedge clk);
      check("load_state", 32'(state), 32'd0);
      check("load_ready", 32'(ld_ready), 32'd1);
      hs = ld_ready;
      @(posedge clk); #1;
      if (hs) acc++;
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("load_count", 32'(acc), 32'(n));
  endtask

  task automatic run_scenario(input int ncyc);
    int es, r;
    logic [31:0] w, exp_iss;
    compute_model();
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      es = exp_state(k);
      r  = k - RST_C;
      if (es == 2) begin
        if (mode_s) exp_q.push_back(prog[r]);
        else begin
          w = pc_seq[k] >> 2;
          exp_q.push_back((w < 32'(plen)) ? prog[w[1:0]] : NOP);
        end
      end else exp_q.push_back(NOP);
    end
    for (int k = 0; k < ncyc; k++) begin
      pc = pc_seq[k];
      @(negedge clk);
      es = exp_state(k);
      r  = k - RST_C;
      if (!mode_s)      exp_iss = 0;
      else if (es == 1) exp_iss = 0;
      else if (es == 2) exp_iss = 32'(r);
      else              exp_iss = 32'(plen);
      check("state", 32'(state), 32'(es));
      check("core_rst_n", 32'(core_rst_n), 32'(es == 2 || es == 3 || es == 4));
      check("done", 32'(done), 32'(es == 4));
      check("timeout", 32'(timeout), 32'(es == 5));
      check("ld_ready_run", 32'(ld_ready), 32'd0);
      check("prog_len", 32'(prog_len), 32'(plen));
      check("issued", 32'(issued), exp_iss);
      check("instr", instr, exp_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  // stimulus
  initial begin
    logic [31:0] ov[6];
    int acc;
    int oor_div;
    int widx;

    rst_n = 1'b0; restart = 1'b0; mode = 1'b0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; pc = '0;
    for (int k = 0; k < KMAX; k++) pc_seq[k] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_issued", 32'(issued), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDR program from the plan
    prog[0] = 32'h2001000A; prog[1] = 32'h2002000B; prog[2] = 32'h00221820;
    plen = 3; mode_s = 1'b0; mode = 1'b0;
    pc_seq[1] = 32'h4; pc_seq[2] = 32'h5; pc_seq[3] = 32'hC;
    load_prog(3, 1'b1);
    run_scenario(20);

    // STREAM, 4 words, random pc
    restart_pulse();
    for (int i = 0; i < 4; i++) prog[i] = $urandom;
    for (int k = 0; k < KMAX; k++) pc_seq[k] = $urandom;
    plen = 4; mode_s = 1'b1; mode = 1'b1;
    load_prog(4, 1'b1);
    run_scenario(20);

    // overflow: 6 words, no ld_last
    restart_pulse();
    mode = 1'b0; pc = '0; acc = 0;
    for (int i = 0; i < 6; i++) ov[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = ov[i]; ld_last = 1'b0;
      @(negedge clk);
      if (i == 4) check("ovf_core_rst", 32'(state), 32'd1);
      check("ovf_ready", 32'(ld_ready), 32'(i < 4));
      if (ld_ready) acc++;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("ovf_accepted", 32'(acc), 32'd4);
    check("ovf_prog_len", 32'(prog_len), 32'd4);
    check("ovf_word0", instr, ov[0]);
    @(posedge clk); #1;

    // watchdog: ADDR with pc held at 0
    restart_pulse();
    prog[0] = $urandom; prog[1] = $urandom;
    for (int k = 0; k < KMAX; k++) pc_seq[k] = '0;
    plen = 2; mode_s = 1'b0; mode = 1'b0;
    load_prog(2, 1'b1);
    run_scenario(60);

    // restart in STREAM RUN after 2 issued, with a load handshake that must be ignored
    restart_pulse();
    for (int i = 0; i < 4; i++) prog[i] = $urandom;
    plen = 4; mode_s = 1'b1; mode = 1'b1;
    load_prog(4, 1'b1);
    run_scenario(3);
    restart = 1'b1; ld_valid = 1'b1; ld_data = 32'h1234_5678; ld_last = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("rs_state", 32'(state), 32'd0);
    check("rs_prog_len", 32'(prog_len), 32'd0);
    check("rs_issued", 32'(issued), 32'd0);
    check("rs_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rs_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    prog[0] = $urandom; plen = 1;
    load_prog(1, 1'b1);
    run_scenario(16);

    // rst_n mid-LOAD with a handshake pending
    restart_pulse();
    mode = 1'b0;
    prog[0] = $urandom; prog[1] = $urandom; prog[2] = $urandom;
    load_prog(2, 1'b0);
    ld_valid = 1'b1; ld_data = prog[2];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_prog_len", 32'(prog_len), 32'd0);
    check("ar_core_rst_n", 32'(core_rst_n), 32'd0);
    check("ar_instr", instr, NOP);
    ld_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized programs, modes and PC streams
    for (int it = 0; it < 14; it++) begin
      restart_pulse();
      plen    = $urandom_range(1, DEPTH);
      mode_s  = 1'($urandom_range(0, 1));
      mode    = mode_s;
      oor_div = $urandom_range(2, 60);
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      for (int k = 0; k < KMAX; k++) begin
        if ($urandom_range(0, oor_div - 1) == 0) widx = $urandom_range(plen, 1 << 20);
        else                                     widx = $urandom_range(0, plen - 1);
        pc_seq[k] = 32'(widx) * 4 + 32'($urandom_range(0, 3));
      end
      load_prog(plen, 1'b1);
      run_scenario(KMAX);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
